// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: 32-cycle shift-add multiply and
// restoring divide, with a final sign-fix cycle and MFHI/MFLO read-out.
module muldiv_sequencer #(
  parameter int          ITERATIONS  = 32,
  parameter logic [5:0]  FUNCT_MULT  = 6'b011000,
  parameter logic [5:0]  FUNCT_MULTU = 6'b011001,
  parameter logic [5:0]  FUNCT_DIV   = 6'b011010,
  parameter logic [5:0]  FUNCT_DIVU  = 6'b011011,
  parameter logic [5:0]  FUNCT_MFHI  = 6'b010000,
  parameter logic [5:0]  FUNCT_MFLO  = 6'b010010
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable_execute,
  input  logic        op_valid,
  input  logic [5:0]  funct,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  output logic        busy,
  output logic        stall,
  output logic [31:0] dataOut,
  output logic        data_valid,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_prod;
  logic [31:0] r_opnd;
  logic        r_is_div;
  logic        r_dbz_op;
  logic        r_neg_p;
  logic        r_neg_r;
  logic        r_busy;
  logic        r_div_by_zero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_mfhi;
  logic        w_is_mflo;
  logic        w_signed;
  logic        w_accept;
  logic        w_dbz;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic [31:0] w_rem_next;
  logic        w_qbit;
  logic [63:0] w_prod_neg;
  logic [31:0] w_quot_neg;
  logic [31:0] w_rem_neg;

  assign w_is_mul  = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign w_is_div  = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign w_is_mfhi = (funct == FUNCT_MFHI);
  assign w_is_mflo = (funct == FUNCT_MFLO);
  assign w_signed  = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign w_accept  = (r_state == S_IDLE) && enable_execute && op_valid && (w_is_mul || w_is_div);
  assign w_dbz     = w_is_div && (rtData == 32'd0);
  assign w_mag_a   = (w_signed && rsData[31]) ? (32'd0 - rsData) : rsData;
  assign w_mag_b   = (w_signed && rtData[31]) ? (32'd0 - rtData) : rtData;

  // One datapath step: multiply adds into the upper half; divide trial-subtracts the shifted remainder.
  always_comb begin
    w_sum      = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_opnd} : 33'd0);
    w_shift    = {r_prod[63:32], r_prod[31]};
    w_diff     = w_shift - {1'b0, r_opnd};
    w_qbit     = ~w_diff[32];
    w_rem_next = w_qbit ? w_diff[31:0] : w_shift[31:0];
    w_prod_neg = 64'd0 - r_prod;
    w_quot_neg = 32'd0 - r_prod[31:0];
    w_rem_neg  = 32'd0 - r_prod[63:32];
  end

  // Sequencer FSM, iteration datapath and architectural HI/LO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 6'd0;
      r_prod        <= 64'd0;
      r_opnd        <= 32'd0;
      r_is_div      <= 1'b0;
      r_dbz_op      <= 1'b0;
      r_neg_p       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_busy        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_hi          <= 32'd0;
      r_lo          <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_busy   <= 1'b1;
            r_cnt    <= 6'd0;
            r_is_div <= w_is_div;
            r_neg_p  <= w_signed && (rsData[31] ^ rtData[31]);
            r_neg_r  <= w_signed && rsData[31];
            r_dbz_op <= w_dbz;
            if (w_dbz) begin
              r_opnd  <= rsData;
              r_prod  <= 64'd0;
              r_state <= S_FIX;
            end else if (w_is_mul) begin
              r_opnd  <= w_mag_a;
              r_prod  <= {32'd0, w_mag_b};
              r_state <= S_MUL;
            end else begin
              r_opnd  <= w_mag_b;
              r_prod  <= {32'd0, w_mag_a};
              r_state <= S_DIV;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (r_state == S_MUL) begin
            r_prod <= {w_sum, r_prod[31:1]};
          end else begin
            r_prod <= {w_rem_next, r_prod[30:0], w_qbit};
          end
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == LAST_ITER) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (r_dbz_op) begin
            r_hi          <= r_opnd;
            r_lo          <= 32'hFFFF_FFFF;
            r_div_by_zero <= 1'b1;
          end else if (r_is_div) begin
            r_lo <= r_neg_p ? w_quot_neg : r_prod[31:0];
            r_hi <= r_neg_r ? w_rem_neg  : r_prod[63:32];
          end else begin
            {r_hi, r_lo} <= r_neg_p ? w_prod_neg : r_prod;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // MFHI/MFLO read port; reads only complete when no operation is pending.
  always_comb begin
    dataOut    = 32'd0;
    data_valid = 1'b0;
    if (op_valid && !r_busy && w_is_mfhi) begin
      dataOut    = r_hi;
      data_valid = 1'b1;
    end else if (op_valid && !r_busy && w_is_mflo) begin
      dataOut    = r_lo;
      data_valid = 1'b1;
    end else begin
      dataOut    = 32'd0;
      data_valid = 1'b0;
    end
  end

  assign stall       = op_valid && enable_execute && r_busy && (w_is_mul || w_is_div || w_is_mfhi || w_is_mflo);
  assign busy        = r_busy;
  assign div_by_zero = r_div_by_zero;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed HI/LO results, latency,
// stall/read-port behaviour, divide-by-zero and mid-operation reset.
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic        clock;
  logic        reset_n;
  logic        enable_execute;
  logic        op_valid;
  logic [5:0]  funct;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic        busy;
  logic        stall;
  logic [31:0] dataOut;
  logic        data_valid;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int edges;
  int bad_stall;

  muldiv_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable_execute (enable_execute),
    .op_valid       (op_valid),
    .funct          (funct),
    .rsData         (rsData),
    .rtData         (rtData),
    .busy           (busy),
    .stall          (stall),
    .dataOut        (dataOut),
    .data_valid     (data_valid),
    .div_by_zero    (div_by_zero),
    .hi             (hi),
    .lo             (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an op for one edge (E0), then count edges until busy drops.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clock);
    op_valid = 1'b1; enable_execute = 1'b1; funct = f; rsData = a; rtData = b;
    @(posedge clock); #1;
    op_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  initial begin
    reset_n = 1'b0; enable_execute = 1'b0; op_valid = 1'b0;
    funct = 6'd0; rsData = 32'd0; rtData = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clock); reset_n = 1'b1;

    // MULT -3 * 5
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, edges);
    check("mult_lat", edges, 32'd33);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    op_valid = 1'b1; enable_execute = 1'b1; funct = F_MFLO; #3;
    check("mflo_data", dataOut, 32'hFFFF_FFF1);
    check("mflo_valid", {31'd0, data_valid}, 32'd1);
    check("mflo_stall", {31'd0, stall}, 32'd0);
    op_valid = 1'b0;

    // MULTU and DIVU
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'd2, edges);
    check("multu_hi", hi, 32'd1);
    check("multu_lo", lo, 32'hFFFF_FFFE);
    run_op(F_DIVU, 32'd100, 32'd7, edges);
    check("divu_lat", edges, 32'd33);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // Signed DIV, including the overflow corner
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, edges);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, edges);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // Divide by zero: two-edge latency, sticky flag
    run_op(F_DIVU, 32'd9, 32'd0, edges);
    check("dbz_lat", edges, 32'd1);
    check("dbz_hi", hi, 32'd9);
    check("dbz_lo", lo, 32'hFFFF_FFFF);
    check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    run_op(F_MULT, 32'd6, 32'd7, edges);
    check("dbz_sticky_lo", lo, 32'd42);
    check("dbz_sticky", {31'd0, div_by_zero}, 32'd1);

    // enable_execute low: no accept, no stall
    @(negedge clock);
    op_valid = 1'b1; enable_execute = 1'b0; funct = F_MULT; rsData = 32'd2; rtData = 32'd3;
    @(posedge clock); #1;
    check("noen_busy", {31'd0, busy}, 32'd0);
    check("noen_stall", {31'd0, stall}, 32'd0);
    op_valid = 1'b0; enable_execute = 1'b1;

    // MULT 2^16*2^16 with a competing MULT at E1..E4 and MFHI from E5
    @(negedge clock);
    op_valid = 1'b1; funct = F_MULT; rsData = 32'h0001_0000; rtData = 32'h0001_0000;
    @(posedge clock); #1;
    funct = F_MULT; rsData = 32'd2; rtData = 32'd3;
    edges = 0;
    repeat (4) begin
      @(posedge clock); #1;
      edges++;
    end
    check("busy_stall_mult", {31'd0, stall}, 32'd1);
    funct = F_MFHI; #1;
    check("mfhi_busy_stall", {31'd0, stall}, 32'd1);
    check("mfhi_busy_valid", {31'd0, data_valid}, 32'd0);
    check("mfhi_busy_data", dataOut, 32'd0);
    bad_stall = 0;
    while (busy && edges < 100) begin
      @(posedge clock); #1;
      edges++;
      if (busy && (stall !== 1'b1 || data_valid !== 1'b0)) bad_stall++;
    end
    check("mfhi_lat", edges, 32'd33);
    check("mfhi_stall_hold", bad_stall, 32'd0);
    check("mfhi_after_stall", {31'd0, stall}, 32'd0);
    check("mfhi_after_valid", {31'd0, data_valid}, 32'd1);
    check("mfhi_after_data", dataOut, 32'd1);
    op_valid = 1'b0;
    @(posedge clock); #1;
    check("no_queue_busy", {31'd0, busy}, 32'd0);
    check("no_queue_lo", lo, 32'd0);

    // Preload HI=LO=0x12345678 via (641*1413981)*(6700417*216) = 0x12345678*(2^32+1)
    run_op(F_MULTU, 32'd906361821, 32'd1447290072, edges);
    check("pre_hi", hi, 32'h1234_5678);
    check("pre_lo", lo, 32'h1234_5678);
    @(negedge clock);
    op_valid = 1'b1; funct = F_DIV; rsData = 32'd50; rtData = 32'd5;
    @(posedge clock); #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0; #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    run_op(F_MULT, 32'd3, 32'd4, edges);
    check("post_rst_lat", edges, 32'd33);
    check("post_rst_lo", lo, 32'd12);
    check("post_rst_hi", hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit beside the execute-stage ALU. Owns the architectural HI/LO registers.
- Sequences MULT/MULTU/DIV/DIVU as iterative shift-add and restoring-divide operations, and serves MFHI/MFLO.
- Raises stall to the pipeline while a result is pending. The ALU keeps all single-cycle ops; this block takes only the R-type funct codes listed below.

Parameters:
- ITERATIONS, 32, datapath iterations per operation; fixed at operand width 32.
- FUNCT_MULT/MULTU/DIV/DIVU/MFHI/MFLO, 6'b011000/011001/011010/011011/010000/010010, R-type funct encodings.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable_execute  in  1  execute stage active; new ops accepted only when high
- op_valid  in  1  R-type instruction with a muldiv funct present this cycle
- funct  in  6  insn[5:0]
- rsData  in  32  operand A (multiplicand / dividend)
- rtData  in  32  operand B (multiplier / divisor)
- busy  out  1  operation in progress (registered)
- stall  out  1  hold pipeline (combinational)
- dataOut  out  32  MFHI/MFLO result (combinational)
- data_valid  out  1  dataOut valid this cycle
- div_by_zero  out  1  sticky flag; set by DIV/DIVU with rtData==0
- hi, lo  out  32  current HI/LO (debug/forwarding)

Behaviour:
- Reset (async, reset_n=0) clears all state: state=IDLE, hi=lo=0, busy=0, div_by_zero=0, internal accumulators=0. Combinational outputs derive from the cleared state.
- Reset mid-operation aborts the op. HI/LO are not updated.
- Accept condition: state==IDLE && enable_execute && op_valid && funct is MULT/MULTU/DIV/DIVU.
  - At that edge E0, operands are latched. For signed ops, magnitudes and result-sign bits are latched.
- States:
  - IDLE -> MUL or DIV on accept.
  - MUL/DIV -> FIX after ITERATIONS edges (E1..E32). 6-bit iteration counter.
  - FIX -> IDLE at E33. FIX applies sign correction and writes HI/LO.
  - Total: HI/LO updated at E33; busy=1 from after E0 through E33; busy=0 after E33.
- MUL: 64-bit product via shift-add, one multiplier bit per cycle. HI=product[63:32], LO=product[31:0].
  - Signed (MULT): negate the 64-bit product if the operand signs differ.
- DIV: restoring division, one quotient bit per cycle. LO=quotient, HI=remainder.
  - Signed (DIV): quotient negated if the signs differ; remainder takes the dividend's sign.
  - -2^31 / -1 gives LO=32'h80000000, HI=0 with no exception.
- Divide by zero: on accept, skip DIV and go directly to FIX. Next edge writes HI=rsData, LO=32'hFFFFFFFF and sets div_by_zero. Latency 2 edges.
  - div_by_zero is cleared only by reset.
- MFHI/MFLO (op_valid && funct==MFHI/MFLO):
  - busy=0: dataOut=hi/lo, data_valid=1, stall=0. The write at E33 is visible the cycle after E33.
  - busy=1: stall=1, data_valid=0, dataOut=0.
- stall = op_valid && enable_execute && busy, for any of the six functs. A mult/div presented while busy is not accepted; the pipeline re-presents it after busy drops, with no queueing.
- The same-cycle FIX completion edge does not accept a new op. Acceptance requires IDLE, so back-to-back ops have a gap of at least 1 cycle.
- enable_execute=0: no accept and stall=0. An in-progress op continues to completion.
- Non-muldiv funct or op_valid=0: outputs idle, HI/LO unchanged.

Test Plan:
1. MULT rs=32'hFFFFFFFD (-3), rt=5 -> busy for 33 cycles; at E33 hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; following MFLO gives dataOut=32'hFFFFFFF1, data_valid=1.
2. MULTU rs=32'hFFFFFFFF, rt=2 -> hi=1, lo=32'hFFFFFFFE. DIVU rs=100, rt=7 -> lo=14, hi=2.
3. DIV rs=-7, rt=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIV rs=32'h80000000, rt=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
4. DIVU rs=9, rt=0 -> after 2 edges hi=9, lo=32'hFFFFFFFF, div_by_zero=1, busy low at third cycle; flag stays high through a later valid MULT.
5. MFHI presented at E5 during MULT -> stall=1, data_valid=0 through E33; stall=0, data_valid=1, dataOut=new hi the cycle after E33. A second MULT presented while busy is not accepted; hi/lo reflect only the first op.
6. reset_n pulsed low at E10 of DIV with hi=lo=32'h12345678 preloaded -> immediately busy=0, hi=lo=0, div_by_zero=0. Next MULT 3*4 after reset release -> lo=12 at E33.
